// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared constants for the data-memory arbiter: FSM state encoding and the
// default values of the arbiter parameters.
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

   // Default parameter values
   localparam int ADDR_W_DEF       = 14;  // data-memory word address width
   localparam int MAX_BURST_DEF    = 8;   // max DMA beats per ownership
   localparam int STARVE_LIMIT_DEF = 4;   // DMA wait cycles before DMA wins

   // FSM state encoding
   localparam logic [0:0] ST_IDLE      = 1'b0;
   localparam logic [0:0] ST_DMA_BURST = 1'b1;

endpackage : dmem_arb_pkg

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Arbitrates a single-port, asynchronous-read data memory between the CPU
// MEM stage and a DMA engine. The CPU normally wins; a DMA that has waited
// STARVE_LIMIT cycles takes the memory and may then burst for up to MAX_BURST
// beats while the CPU is stalled.
//
// Ports
//   clk_cpu, rst_cpu          clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata     CPU access request
//   cpu_rdata                 CPU load data (combinational from mem_spo)
//   cpu_stall                 CPU request not serviced this cycle
//   dma_req/we/last/addr/wdata DMA beat request
//   dma_gnt                   DMA beat accepted this cycle
//   dma_rvalid/dma_rdata      registered DMA read return
//   mem_a/mem_d/mem_we        memory address, write data, write enable
//   mem_spo                   memory asynchronous read data
//   dbg_state/beat/starve     internal FSM state and counters, for observation
//
// DMA handshake: a beat transfers in any cycle where dma_req and dma_gnt are
// both high; while dma_req is high and dma_gnt is low the DMA must hold its
// request fields stable. The CPU side is granted in a cycle where cpu_req is
// high and cpu_stall is low.
// -----------------------------------------------------------------------------
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int MAX_BURST    = MAX_BURST_DEF,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
   localparam int BEAT_W      = $clog2(MAX_BURST + 1),
   localparam int STARVE_W    = $clog2(STARVE_LIMIT + 1)
) (
   input  logic                clk_cpu,
   input  logic                rst_cpu,
   input  logic                cpu_req,
   input  logic                cpu_we,
   input  logic [ADDR_W-1:0]   cpu_addr,
   input  logic [31:0]         cpu_wdata,
   output logic [31:0]         cpu_rdata,
   output logic                cpu_stall,
   input  logic                dma_req,
   input  logic                dma_we,
   input  logic                dma_last,
   input  logic [ADDR_W-1:0]   dma_addr,
   input  logic [31:0]         dma_wdata,
   output logic                dma_gnt,
   output logic                dma_rvalid,
   output logic [31:0]         dma_rdata,
   output logic [ADDR_W-1:0]   mem_a,
   output logic [31:0]         mem_d,
   output logic                mem_we,
   input  logic [31:0]         mem_spo,
   output logic [0:0]          dbg_state,
   output logic [BEAT_W-1:0]   dbg_beat,
   output logic [STARVE_W-1:0] dbg_starve
);

   logic [0:0]          r_state;
   logic [BEAT_W-1:0]   r_beat;
   logic [STARVE_W-1:0] r_starve;
   logic                r_rvalid;
   logic [31:0]         r_rdata;

   logic [0:0]          w_state_nxt;
   logic [BEAT_W-1:0]   w_beat_nxt;
   logic [BEAT_W-1:0]   w_beat_inc;
   logic [STARVE_W-1:0] w_starve_nxt;
   logic                w_starved;
   logic                w_cpu_gnt;
   logic                w_dma_gnt;

   assign w_starved  = (r_starve == STARVE_W'(STARVE_LIMIT));
   assign w_beat_inc = r_beat + BEAT_W'(1);

   // Grant decision. Grants are suppressed while reset is held so the memory
   // is never written during reset. In IDLE a starved DMA only beats the CPU
   // while it is still requesting; if it withdrew, the CPU is served anyway.
   always_comb begin
      w_cpu_gnt = 1'b0;
      w_dma_gnt = 1'b0;
      if (!rst_cpu) begin
         if (r_state == ST_IDLE) begin
            if (dma_req && (!cpu_req || w_starved)) begin
               w_dma_gnt = 1'b1;
            end else if (cpu_req) begin
               w_cpu_gnt = 1'b1;
            end
         end else begin
            w_dma_gnt = dma_req;
         end
      end
   end

   // Next-state and beat counter. Leaving a burst always resets the beat
   // count, so IDLE always holds beat == 0.
   always_comb begin
      w_state_nxt = r_state;
      w_beat_nxt  = r_beat;
      case (r_state)
         ST_IDLE: begin
            if (w_dma_gnt && !dma_last && (MAX_BURST > 1)) begin
               w_state_nxt = ST_DMA_BURST;
               w_beat_nxt  = BEAT_W'(1);
            end else begin
               w_beat_nxt  = '0;
            end
         end
         default: begin
            if (!dma_req || dma_last || (w_beat_inc == BEAT_W'(MAX_BURST))) begin
               // abort (no access), final beat, or burst cap reached
               w_state_nxt = ST_IDLE;
               w_beat_nxt  = '0;
            end else begin
               w_beat_nxt  = w_beat_inc;
            end
         end
      endcase
   end

   // Starve counter saturates at STARVE_LIMIT; any DMA grant clears it.
   always_comb begin
      w_starve_nxt = r_starve;
      if (w_dma_gnt) begin
         w_starve_nxt = '0;
      end else if (dma_req && !w_starved) begin
         w_starve_nxt = r_starve + STARVE_W'(1);
      end
   end

   always_ff @(posedge clk_cpu or posedge rst_cpu) begin
      if (rst_cpu) begin
         r_state  <= ST_IDLE;
         r_beat   <= '0;
         r_starve <= '0;
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_beat   <= w_beat_nxt;
         r_starve <= w_starve_nxt;
         r_rvalid <= w_dma_gnt && !dma_we;
         // read data only updates on a granted read; held otherwise
         if (w_dma_gnt && !dma_we) begin
            r_rdata <= mem_spo;
         end
      end
   end

   // Memory mux: the granted requester owns the port; no grant drives zeros.
   assign mem_we = (w_cpu_gnt && cpu_we) || (w_dma_gnt && dma_we);
   assign mem_a  = w_cpu_gnt ? cpu_addr  : (w_dma_gnt ? dma_addr  : '0);
   assign mem_d  = w_cpu_gnt ? cpu_wdata : (w_dma_gnt ? dma_wdata : '0);

   assign cpu_rdata  = w_cpu_gnt ? mem_spo : 32'h0;
   assign cpu_stall  = cpu_req && !w_cpu_gnt;
   assign dma_gnt    = w_dma_gnt;
   assign dma_rvalid = r_rvalid;
   assign dma_rdata  = r_rdata;

   assign dbg_state  = r_state;
   assign dbg_beat   = r_beat;
   assign dbg_starve = r_starve;

endmodule : dmem_arbiter

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, data-memory word address width.
REQ-002 SHALL have parameter MAX_BURST, default 8, maximum DMA beats per ownership.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, consecutive DMA-wait cycles before DMA priority.
REQ-004 clk_cpu  in  1  single clock; all state changes on rising edge.
REQ-005 rst_cpu  in  1  asynchronous, active-high reset.
REQ-006 cpu_req  in  1  MEM-stage access request (load or store).
REQ-007 cpu_we  in  1  CPU store.
REQ-008 cpu_addr  in  ADDR_W  CPU word address.
REQ-009 cpu_wdata  in  32  CPU store data.
REQ-010 cpu_rdata  out  32  CPU load data (combinational).
REQ-011 cpu_stall  out  1  freezes pipeline; request not serviced this cycle.
REQ-012 dma_req / dma_we / dma_last  in  1 each  DMA beat request, write, final beat.
REQ-013 dma_addr  in  ADDR_W; dma_wdata  in  32.
REQ-014 dma_gnt  out  1  DMA beat accepted this cycle.
REQ-015 dma_rvalid  out  1; dma_rdata  out  32  registered DMA read return.
REQ-016 mem_a  out  ADDR_W; mem_d  out  32; mem_we  out  1; mem_spo  in  32 (async-read memory).

Function
REQ-017 SHALL implement states IDLE and DMA_BURST, with a beat counter (0..MAX_BURST) and starve counter (0..STARVE_LIMIT, saturating).
REQ-018 IDLE: cpu_req and starve<STARVE_LIMIT -> CPU granted; cpu_stall=0, dma_gnt=0.
REQ-019 IDLE: dma_req and (!cpu_req or starve==STARVE_LIMIT) -> dma_gnt=1, cpu_stall=cpu_req; next state DMA_BURST unless dma_last, beat=1.
REQ-020 DMA_BURST: dma_gnt=dma_req; cpu_stall=cpu_req; each granted beat increments beat.
REQ-021 DMA_BURST -> IDLE after a granted beat with dma_last, after the beat making beat==MAX_BURST, or in any cycle dma_req=0 (abort, no access).
REQ-022 starve increments when dma_req=1 and dma_gnt=0; clears to 0 on any dma_gnt.
REQ-023 Mem mux: granted requester drives mem_a/mem_d; mem_we = granted requester's we; no grant -> mem_we=0, mem_a=0, mem_d=0.
REQ-024 cpu_rdata = mem_spo when CPU granted, else 0; zero added latency.
REQ-025 dma_rvalid=1 and dma_rdata=mem_spo one cycle after a granted DMA read; dma_rvalid=0 after writes.
REQ-026 At most one grant per cycle; never mem_we=1 without grant.
REQ-027 dma_last on a single IDLE-granted beat: stay IDLE, beat=0.

Reset
REQ-028 rst_cpu asserted: state=IDLE, beat=0, starve=0, dma_rvalid=0, dma_rdata=0 immediately, regardless of clock.
REQ-029 Reset mid-burst: burst dropped; mem_we=0 while reset held; first post-reset cycle obeys IDLE rules.

Structure
REQ-030 Package dmem_arb_pkg SHALL hold the state encoding and default constants (ADDR_W, MAX_BURST, STARVE_LIMIT).
REQ-031 Single module; no sub-module (counters and FSM inline).

Verification
REQ-032 CPU only: cpu_req=1, cpu_we=1, addr=0x10, wdata=0xDEADBEEF -> mem_we=1, cpu_stall=0; next load addr 0x10 -> cpu_rdata=0xDEADBEEF same cycle.
REQ-033 DMA only: 3-beat write burst addrs 0x20-0x22, dma_last on 3rd -> dma_gnt=1 three cycles, state returns IDLE, beat=0.
REQ-034 Contention: cpu_req and dma_req held high -> CPU granted 4 cycles, DMA granted cycle 5 with cpu_stall=1; starve=0 after.
REQ-035 Burst cap: DMA 10 beats no dma_last, cpu_req high -> exactly 8 DMA grants, then CPU granted.
REQ-036 DMA read addr 0x05 holding 0x12345678 -> dma_rvalid=1, dma_rdata=0x12345678 next cycle.
REQ-037 Reset pulse at beat 2 of burst -> outputs at reset values asynchronously; after release, cpu_req serviced first cycle.
